multi_phase_occ_ton: RTL and testbench
======================================

// Module: multi_phase_occ_ton
// PURPOSE
//  Per-channel one-cycle-control on-time calculator for an N-phase interleaved buck discharge stage.
//  Each channel is triggered at its own phase offset within the switching period TS_CLK.
//  At its trigger a channel captures gap voltage, its inductor current and its current reference.
//  One shared sequential divider computes ton = N/D in clk cycles.
//  The result drives the PWM generators of the discharge_control path.
// PARAMETERS
//  N_CH       2     channel count, power of two, 1..8
//  VIN        120   bus voltage, V
//  L_NH       3300  inductance, nH
//  F_CLK_MHZ  100   clk frequency, MHz
//  TS_CLK     400   switching period, clk cycles; TS_CLK/N_CH >= 64
//  TON_MAX    200   on-time ceiling, clk cycles
//  I_REF_MAX  50    per-channel reference ceiling, A
//  NEG_STEP   5     value substituted for (i_ref - i_d) when that difference is negative
//  I_SLEW     1     per-period i_ref step limit, A; used only with OCC_SOFTSTART_EN
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        asynchronous active-low reset
//  period_cnt     in   16       period timer, counts 0..TS_CLK-1
//  sample_current in   16*N_CH  filtered inductor current per channel; ch k at [16k+:16], signed
//  sample_voltage in   16       filtered gap voltage, unsigned
//  i_set          in   16       total current setpoint, A
//  ton            out  16*N_CH  on-time per channel, clk cycles
//  ton_valid      out  N_CH     1-cycle pulse when ton[k] updates
//  overrun        out  1        sticky; set when a channel retriggers while still pending; cleared only by reset
// BEHAVIOUR
//  Reset: ton=0, ton_valid=0, overrun=0, all pending flags=0, FSM=IDLE.
//  Trigger k: period_cnt == k*TS_CLK/N_CH.
//  On trigger k the channel captures:
//   id_k = max(sample_current_k, 0)
//   vg_k = sample_voltage
//   iref_k = min(i_set >> log2(N_CH), I_REF_MAX)
//  and sets pend[k].
//  Retrigger while pend[k]=1: the new capture replaces the old one and overrun is set.
//  FSM: IDLE -> PICK -> MUL -> DIV -> WRITE -> IDLE.
//   PICK: takes the lowest-index pending channel and clears its pend bit.
//   MUL: 2 registered stages.
//    di = iref - id; if di < 0 then di = -NEG_STEP.
//    N (48b signed) = vg*(VIN-vg)*TS_CLK + KI*di, with KI = 2*VIN*L_NH*F_CLK_MHZ/1000.
//    D (32b) = 2*VIN*(VIN-vg).
//   DIV: restoring divider, 1 quotient bit per clk, 48 cycles.
//   WRITE: applies the clamp, updates ton[k] and pulses ton_valid[k].
//  Clamp:
//   vg >= VIN or N <= 0 -> 0 (DIV is skipped; MUL goes straight to WRITE).
//   q > TS_CLK -> 0 (implausible result, treated as fault).
//   TON_MAX < q <= TS_CLK -> TON_MAX.
//   otherwise -> q[15:0].
//  Latency from trigger to ton_valid, channel idle: 1 capture + 1 PICK + 2 MUL + 48 DIV + 1 WRITE = 53 clk.
//  Simultaneous trigger and PICK of the same channel: PICK uses the old capture; pend stays set for the new one.
//  ton[k] holds its value between updates.
//  rst_n asserted mid-divide aborts the divide; ton returns to 0.
// CONFIGURATION
//  OCC_SOFTSTART_EN defined: each capture moves iref_eff_k toward the target by at most I_SLEW.
//   iref_eff_k resets to 0.
//  OCC_SOFTSTART_EN undefined: iref_eff_k = target, applied immediately.
// STRUCTURE
//  Package occ_pkg holds:
//   FSM state enum (IDLE, PICK, MUL, DIV, WRITE)
//   function computing KI
//   numerator/denominator width localparams (48/32)
//  Sub-module occ_seq_divider: unsigned 48/32 restoring divider.
//   Handshake: start/busy/done, quotient 48b.
//   Quotient is wide enough to detect q > TS_CLK.
// TESTING (defaults: N_CH=2, VIN=120, TS_CLK=400, KI=79200)
//  vg=60, i_set=40, id0=20 -> N=1440000, D=14400 -> ton[0]=100, ton_valid[0] 53 clk after the trigger.
//  vg=60, i_set=44, id0=20 -> di=+2 -> ton[0]=111.
//  vg=60, i_set=40, id0=45 -> di=-5 -> ton[0]=72.
//  vg=60, i_set=200, id0=0 -> iref=50, q=375 -> ton[0]=200 (TON_MAX).
//  vg=100, i_set=200, id0=0 -> q=991 > 400 -> ton[0]=0.
//  vg=120 -> ton=0, no divide.
//  Both channels pending: ch0 written before ch1.
//  Force ch0 retrigger before service: overrun=1, latest capture used.
//  With OCC_SOFTSTART_EN, i_set 0->100: iref_eff 1,2,3... per period.
//  Reset mid-divide: all outputs 0.

Source files
------------

// File: rtl/multi_phase_occ_ton_pkg.sv
// ------------------------------------------------------------------
// occ_pkg : shared types and constants for the OCC on-time slice
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package occ_pkg;

   localparam int NUM_W = 48;
   localparam int DEN_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PICK  = 3'd1,
      MUL   = 3'd2,
      DIV   = 3'd3,
      WRITE = 3'd4
   } occ_state_t;

   // Current-loop gain in clk-cycle units: 2*VIN*L[nH]*F[MHz]/1000.
   function automatic longint occ_ki(input longint vin, input longint l_nh, input longint f_mhz);
      return (2 * vin * l_nh * f_mhz) / 1000;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_phase_occ_ton_if.sv
// ------------------------------------------------------------------
// multi_phase_occ_ton_if : sample inputs and on-time outputs bundle
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface multi_phase_occ_ton_if #(
   parameter int N_CH = 2
);
   logic [15:0]          period_cnt;
   logic [16*N_CH-1:0]   sample_current;
   logic [15:0]          sample_voltage;
   logic [15:0]          i_set;
   logic [16*N_CH-1:0]   ton;
   logic [N_CH-1:0]      ton_valid;
   logic                 overrun;

   modport master (
      output period_cnt, sample_current, sample_voltage, i_set,
      input  ton, ton_valid, overrun
   );

   modport slave (
      input  period_cnt, sample_current, sample_voltage, i_set,
      output ton, ton_valid, overrun
   );
endinterface

`default_nettype wire

// File: rtl/multi_phase_occ_ton_divider.sv
// ------------------------------------------------------------------
// occ_seq_divider : unsigned 48/32 restoring divider, one bit per clk
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module occ_seq_divider
   import occ_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_num,
   input  logic [DEN_W-1:0] i_den,
   output logic             o_busy,
   output logic             o_done,
   output logic [NUM_W-1:0] o_quot
);
   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [DEN_W-1:0] r_rem;
   logic [NUM_W-1:0] r_q;
   logic [DEN_W-1:0] r_den;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;

   logic [DEN_W-1:0] w_rem_src;
   logic [NUM_W-1:0] w_q_src;
   logic [DEN_W-1:0] w_den_src;
   logic [DEN_W:0]   w_trial;
   logic [DEN_W-1:0] w_diff;
   logic             w_ge;

   // The start cycle already performs the first quotient bit on the fresh operands.
   always_comb begin
      w_rem_src = i_start ? '0    : r_rem;
      w_q_src   = i_start ? i_num : r_q;
      w_den_src = i_start ? i_den : r_den;
      w_trial   = {w_rem_src, w_q_src[NUM_W-1]};
      w_ge      = w_trial[DEN_W] | (w_trial[DEN_W-1:0] >= w_den_src);
      w_diff    = w_trial[DEN_W-1:0] - w_den_src;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_q    <= '0;
         r_den  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start || r_busy) begin
            r_rem <= w_ge ? w_diff : w_trial[DEN_W-1:0];
            r_q   <= {w_q_src[NUM_W-2:0], w_ge};
            r_den <= w_den_src;
         end
         if (i_start) begin
            r_cnt  <= CNT_W'(NUM_W - 1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_quot = r_q;

endmodule

`default_nettype wire

// File: rtl/multi_phase_occ_ton.sv
// ------------------------------------------------------------------
// multi_phase_occ_ton : N-phase one-cycle-control on-time calculator
// optional build macro OCC_SOFTSTART_EN (slew-limited i_ref)  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module multi_phase_occ_ton
   import occ_pkg::*;
#(
   parameter int N_CH      = 2,
   parameter int VIN       = 120,
   parameter int L_NH      = 3300,
   parameter int F_CLK_MHZ = 100,
   parameter int TS_CLK    = 400,
   parameter int TON_MAX   = 200,
   parameter int I_REF_MAX = 50,
   parameter int NEG_STEP  = 5
`ifdef OCC_SOFTSTART_EN
   ,
   parameter int I_SLEW    = 1
`endif
)(
   input  logic                  clk,
   input  logic                  rst_n,
   multi_phase_occ_ton_if.slave  bus
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SH   = $clog2(N_CH);
   localparam logic signed [NUM_W-1:0] C_KI       = NUM_W'(occ_ki(VIN, L_NH, F_CLK_MHZ));
   localparam logic signed [NUM_W-1:0] C_TS       = NUM_W'(TS_CLK);
   localparam logic [15:0]             C_VIN      = 16'(VIN);
   localparam logic [DEN_W-1:0]        C_2VIN     = DEN_W'(2 * VIN);
   localparam logic [15:0]             C_IREF_MAX = 16'(I_REF_MAX);
   localparam logic signed [17:0]      C_NEG      = 18'(-NEG_STEP);

   occ_state_t        r_state;
   logic [N_CH-1:0]   r_pend;
   logic              r_overrun;
   logic [15:0]       r_id   [N_CH];
   logic [15:0]       r_vg   [N_CH];
   logic [15:0]       r_iref [N_CH];
   logic [15:0]       r_ton  [N_CH];
   logic [N_CH-1:0]   r_ton_valid;

   logic [CH_W-1:0]         r_ch;
   logic [15:0]             r_op_vg;
   logic [15:0]             r_op_id;
   logic [15:0]             r_op_iref;
   logic [31:0]             r_pvv;
   logic signed [NUM_W-1:0] r_kdi;
   logic [DEN_W-1:0]        r_den;
   logic                    r_vg_hi;
   logic                    r_mul_stg;
   logic                    r_zero;

   logic [15:0]             w_cur [N_CH];
   logic [N_CH-1:0]         w_trig;
   logic [N_CH-1:0]         w_clr;
   logic [CH_W-1:0]         w_pick;
   logic [15:0]             w_iset_sh;
   logic [15:0]             w_target;
   logic [15:0]             w_vdiff;
   logic signed [17:0]      w_di;
   logic signed [17:0]      w_di_sat;
   logic signed [NUM_W-1:0] w_num;
   logic                    w_skip;
   logic                    w_div_start;
   logic                    w_div_busy;
   logic                    w_div_done;
   logic [NUM_W-1:0]        w_quot;
   logic [15:0]             w_ton;

   genvar gk;
   generate
      for (gk = 0; gk < N_CH; gk++) begin : g_ch
         assign w_cur[gk]            = bus.sample_current[16*gk +: 16];
         assign w_trig[gk]           = (bus.period_cnt == 16'(gk * TS_CLK / N_CH));
         assign bus.ton[16*gk +: 16] = r_ton[gk];
      end
   endgenerate

   assign bus.ton_valid = r_ton_valid;
   assign bus.overrun   = r_overrun;

   assign w_iset_sh = bus.i_set >> SH;
   assign w_target  = (w_iset_sh > C_IREF_MAX) ? C_IREF_MAX : w_iset_sh;

   always_comb begin
      w_pick = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (r_pend[k]) w_pick = CH_W'(k);
      end
      w_clr = '0;
      if (r_state == PICK) w_clr[w_pick] = 1'b1;
   end

   // A trigger landing on the PICK cycle re-arms pend; that old capture is consumed, not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend    <= '0;
         r_overrun <= 1'b0;
         for (int k = 0; k < N_CH; k++) begin
            r_id[k]   <= '0;
            r_vg[k]   <= '0;
            r_iref[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (w_trig[k]) begin
               r_id[k]   <= w_cur[k][15] ? 16'd0 : w_cur[k];
               r_vg[k]   <= bus.sample_voltage;
`ifdef OCC_SOFTSTART_EN
               if (w_target > r_iref[k] + 16'(I_SLEW))
                  r_iref[k] <= r_iref[k] + 16'(I_SLEW);
               else if (r_iref[k] > w_target + 16'(I_SLEW))
                  r_iref[k] <= r_iref[k] - 16'(I_SLEW);
               else
                  r_iref[k] <= w_target;
`else
               r_iref[k] <= w_target;
`endif
               r_pend[k] <= 1'b1;
               if (r_pend[k] && !w_clr[k]) r_overrun <= 1'b1;
            end else if (w_clr[k]) begin
               r_pend[k] <= 1'b0;
            end
         end
      end
   end

   assign w_vdiff     = C_VIN - r_op_vg;
   assign w_di        = $signed({2'b00, r_op_iref}) - $signed({2'b00, r_op_id});
   assign w_di_sat    = (w_di < 18'sd0) ? C_NEG : w_di;
   assign w_num       = $signed({16'd0, r_pvv}) * C_TS + r_kdi;
   assign w_skip      = r_vg_hi || (w_num <= 48'sd0);
   assign w_div_start = (r_state == MUL) && r_mul_stg && !w_skip;

   always_comb begin
      w_ton = w_quot[15:0];
      if (r_zero || (w_quot > NUM_W'(TS_CLK)))
         w_ton = 16'd0;
      else if (w_quot > NUM_W'(TON_MAX))
         w_ton = 16'(TON_MAX);
   end

   occ_seq_divider u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_div_start),
      .i_num   (NUM_W'(w_num)),
      .i_den   (r_den),
      .o_busy  (w_div_busy),
      .o_done  (w_div_done),
      .o_quot  (w_quot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ch        <= '0;
         r_op_vg     <= '0;
         r_op_id     <= '0;
         r_op_iref   <= '0;
         r_pvv       <= '0;
         r_kdi       <= '0;
         r_den       <= '0;
         r_vg_hi     <= 1'b0;
         r_mul_stg   <= 1'b0;
         r_zero      <= 1'b0;
         r_ton_valid <= '0;
         for (int k = 0; k < N_CH; k++) r_ton[k] <= '0;
      end else begin
         r_ton_valid <= '0;
         case (r_state)
            IDLE: begin
               if (|r_pend) r_state <= PICK;
            end
            PICK: begin
               r_ch      <= w_pick;
               r_op_vg   <= r_vg[w_pick];
               r_op_id   <= r_id[w_pick];
               r_op_iref <= r_iref[w_pick];
               r_mul_stg <= 1'b0;
               r_state   <= MUL;
            end
            MUL: begin
               if (!r_mul_stg) begin
                  r_pvv     <= 32'(r_op_vg) * 32'(w_vdiff);
                  r_kdi     <= C_KI * $signed({{(NUM_W-18){w_di_sat[17]}}, w_di_sat});
                  r_den     <= C_2VIN * {16'd0, w_vdiff};
                  r_vg_hi   <= (r_op_vg >= C_VIN);
                  r_mul_stg <= 1'b1;
               end else begin
                  r_zero  <= w_skip;
                  r_state <= w_skip ? WRITE : DIV;
               end
            end
            DIV: begin
               if (w_div_done && !w_div_busy) r_state <= WRITE;
            end
            WRITE: begin
               r_ton[r_ch]       <= w_ton;
               r_ton_valid[r_ch] <= 1'b1;
               r_state           <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_phase_occ_ton.sv
// ------------------------------------------------------------------
// tb_multi_phase_occ_ton : directed self-checking bench, N_CH=2 defaults
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_multi_phase_occ_ton;

   localparam logic [15:0] IDLE_PC = 16'd100;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   multi_phase_occ_ton_if #(.N_CH(2)) bus ();

   multi_phase_occ_ton #(.N_CH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input int vg, input int iset, input int c0, input int c1);
      bus.sample_voltage = 16'(vg);
      bus.i_set          = 16'(iset);
      bus.sample_current = {16'(c1), 16'(c0)};
   endtask

   // Presents period_cnt=pc for exactly one sampling edge.
   task automatic fire(input logic [15:0] pc);
      bus.period_cnt = pc;
      @(posedge clk); #1;
      bus.period_cnt = IDLE_PC;
   endtask

   task automatic wait_valid(input int budget, output int lat, output logic [1:0] v);
      lat = -1;
      v   = 2'b00;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk); #1;
         if (|bus.ton_valid) begin
            lat = i;
            v   = bus.ton_valid;
            return;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.ton !== 32'd0) begin
         errors++; $display("FAIL reset_ton: got %h expected 0", bus.ton);
      end
      checks++;
      if (bus.ton_valid !== 2'b00) begin
         errors++; $display("FAIL reset_valid: got %b expected 00", bus.ton_valid);
      end
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun);
      end
   endtask

   task automatic test_nominal();
      int lat; logic [1:0] v;
      set_in(60, 40, 20, 0);
      fire(16'd0);
      wait_valid(80, lat, v);
      checks++;
      if (lat !== 53) begin
         errors++; $display("FAIL nominal_latency: got %0d expected 53", lat);
      end
      checks++;
      if (v !== 2'b01) begin
         errors++; $display("FAIL nominal_valid: got %b expected 01", v);
      end
      checks++;
      if (bus.ton[15:0] !== 16'd100) begin
         errors++; $display("FAIL nominal_ton0: got %0d expected 100", bus.ton[15:0]);
      end
      checks++;
      if (bus.ton[31:16] !== 16'd0) begin
         errors++; $display("FAIL nominal_ton1: got %0d expected 0", bus.ton[31:16]);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.ton_valid !== 2'b00 || bus.ton[15:0] !== 16'd100) begin
         errors++; $display("FAIL nominal_hold: got valid=%b ton0=%0d expected 00/100", bus.ton_valid, bus.ton[15:0]);
      end
   endtask

   task automatic test_clamp_table();
      int vg_t[6]  = '{60, 60, 60, 100, 120, 1};
      int is_t[6]  = '{44, 40, 200, 200, 40, 40};
      int id_t[6]  = '{20, 45, 0, 0, 20, 45};
      int ex_t[6]  = '{111, 72, 200, 0, 0, 0};
      int lat_t[6] = '{53, 53, 53, 53, 5, 5};
      int lat; logic [1:0] v;
      for (int i = 0; i < 6; i++) begin
         if (i >= 4) begin
            set_in(60, 40, 20, 0);
            fire(16'd0);
            wait_valid(80, lat, v);
         end
         set_in(vg_t[i], is_t[i], id_t[i], 0);
         fire(16'd0);
         wait_valid(80, lat, v);
         checks++;
         if (lat !== lat_t[i] || v !== 2'b01) begin
            errors++; $display("FAIL clamp_latency[%0d]: got %0d/%b expected %0d/01", i, lat, v, lat_t[i]);
         end
         checks++;
         if (bus.ton[15:0] !== 16'(ex_t[i])) begin
            errors++; $display("FAIL clamp_ton0[%0d]: got %0d expected %0d", i, bus.ton[15:0], ex_t[i]);
         end
      end
   endtask

   task automatic test_both_pending();
      int lat; logic [1:0] v;
      set_in(60, 40, 20, 10);
      fire(16'd0);
      fire(16'd200);
      wait_valid(80, lat, v);
      checks++;
      if (lat !== 52 || v !== 2'b01 || bus.ton[15:0] !== 16'd100) begin
         errors++; $display("FAIL both_first: got lat=%0d v=%b ton0=%0d expected 52/01/100", lat, v, bus.ton[15:0]);
      end
      wait_valid(80, lat, v);
      checks++;
      if (lat !== 53 || v !== 2'b10 || bus.ton[31:16] !== 16'd155) begin
         errors++; $display("FAIL both_second: got lat=%0d v=%b ton1=%0d expected 53/10/155", lat, v, bus.ton[31:16]);
      end
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++; $display("FAIL both_overrun: got %b expected 0", bus.overrun);
      end
   endtask

   task automatic test_overrun();
      int lat; logic [1:0] v;
      set_in(60, 40, 20, 0);
      fire(16'd0);
      set_in(60, 40, 45, 0);
      fire(16'd0);
      checks++;
      if (bus.overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_flag: got %b expected 1", bus.overrun);
      end
      wait_valid(80, lat, v);
      checks++;
      if (v !== 2'b01 || bus.ton[15:0] !== 16'd72) begin
         errors++; $display("FAIL overrun_latest: got v=%b ton0=%0d expected 01/72", v, bus.ton[15:0]);
      end
      wait_valid(80, lat, v);
      checks++;
      if (lat !== -1) begin
         errors++; $display("FAIL overrun_extra_write: got lat=%0d expected none", lat);
      end
   endtask

   task automatic test_pick_collision();
      int lat; logic [1:0] v;
      set_in(60, 40, 20, 0);
      fire(16'd0);
      @(posedge clk); #1;
      set_in(60, 40, 45, 0);
      fire(16'd0);
      wait_valid(80, lat, v);
      checks++;
      if (lat !== 51 || bus.ton[15:0] !== 16'd100) begin
         errors++; $display("FAIL collision_old: got lat=%0d ton0=%0d expected 51/100", lat, bus.ton[15:0]);
      end
      wait_valid(80, lat, v);
      checks++;
      if (lat !== 53 || v !== 2'b01 || bus.ton[15:0] !== 16'd72) begin
         errors++; $display("FAIL collision_new: got lat=%0d v=%b ton0=%0d expected 53/01/72", lat, v, bus.ton[15:0]);
      end
   endtask

   task automatic test_reset_mid_divide();
      int lat; logic [1:0] v;
      set_in(60, 40, 20, 0);
      fire(16'd0);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.ton !== 32'd0 || bus.ton_valid !== 2'b00 || bus.overrun !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs: got ton=%h v=%b ovr=%b expected 0", bus.ton, bus.ton_valid, bus.overrun);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_valid(80, lat, v);
      checks++;
      if (lat !== -1 || bus.ton !== 32'd0) begin
         errors++; $display("FAIL midreset_aborted: got lat=%0d ton=%h expected none/0", lat, bus.ton);
      end
   endtask

`ifdef OCC_SOFTSTART_EN
   task automatic test_softstart();
      int ex_t[3] = '{105, 111, 116};
      int lat; logic [1:0] v;
      set_in(60, 100, 0, 0);
      for (int i = 0; i < 3; i++) begin
         fire(16'd0);
         wait_valid(80, lat, v);
         checks++;
         if (v !== 2'b01 || bus.ton[15:0] !== 16'(ex_t[i])) begin
            errors++; $display("FAIL softstart[%0d]: got v=%b ton0=%0d expected 01/%0d", i, v, bus.ton[15:0], ex_t[i]);
         end
      end
   endtask
`endif

   initial begin
      checks             = 0;
      errors             = 0;
      rst_n              = 1'b0;
      bus.period_cnt     = IDLE_PC;
      bus.sample_current = '0;
      bus.sample_voltage = '0;
      bus.i_set          = '0;
      test_reset();
`ifdef OCC_SOFTSTART_EN
      test_softstart();
`else
      test_nominal();
      test_clamp_table();
      test_both_pending();
      test_overrun();
      test_pick_collision();
      test_reset_mid_divide();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
